// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause 22 MDIO master: one read/write command in, one 64-bit MDC/MDIO frame out
//
// Purpose: accepts a single register command over cmd_valid/cmd_ready, shifts out
// preamble/ST/OP/PHYAD/REGAD/TA/data MSB first on mdio_o/mdio_oe with mdc derived
// from clk (CLK_DIV clk cycles per half period), and for reads captures the PHY's
// 16-bit response, returned with a one-cycle read_data_valid strobe.
//
// Ports:
//   clk, resetn                         system clock, synchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake (cmd_ready=1 only when idle)
//   read_write, reg_adr, write_data     command fields, latched at acceptance
//   read_data_valid, read_data, read_err  read completion strobe, data, no-response flag
//   mdc, mdio_o, mdio_oe, mdio_i        board management pins
module mdio_master #(
  parameter int          CLK_DIV  = 50,
  parameter logic [4:0]  PHY_ADDR = 5'h01
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        read_write,
  input  logic [4:0]  reg_adr,
  input  logic [15:0] write_data,
  output logic        read_data_valid,
  output logic [15:0] read_data,
  output logic        read_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic              phase;      // 0 = low half (mdc=0), 1 = high half
  logic [5:0]        bit_cnt;
  logic [63:0]       frame_sr;   // remaining frame bits, next bit at [63]
  logic              is_read;
  logic [15:0]       rd_stage;
  logic              ta_bit;

  logic [63:0]       frame_full;
  logic              div_last;
  logic              sample;
  logic [15:0]       rd_next;
  logic [15:0]       rd_final;

  // For reads the TA/data positions are never driven (oe=0); fill them with ones.
  assign frame_full = {32'hFFFF_FFFF, 2'b01,
                       read_write ? 2'b10 : 2'b01,
                       PHY_ADDR, reg_adr,
                       read_write ? 2'b11 : 2'b10,
                       read_write ? 16'hFFFF : write_data};

  assign div_last = (div_cnt == DIV_LAST);
  // First cycle of a high half: the cycle in which mdc has just become 1.
  assign sample   = (state == SHIFT) && phase && (div_cnt == '0);
  assign rd_next  = {rd_stage[14:0], mdio_i};
  // With CLK_DIV=1 the last data bit is sampled on the same edge that ends the frame.
  assign rd_final = (sample && (bit_cnt >= 6'd48)) ? rd_next : rd_stage;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      cmd_ready       <= 1'b1;
      read_data_valid <= 1'b0;
      read_data       <= 16'h0000;
      read_err        <= 1'b0;
      mdc             <= 1'b0;
      mdio_o          <= 1'b1;
      mdio_oe         <= 1'b0;
      div_cnt         <= '0;
      phase           <= 1'b0;
      bit_cnt         <= 6'd0;
      frame_sr        <= '1;
      is_read         <= 1'b0;
      rd_stage        <= 16'h0000;
      ta_bit          <= 1'b0;
    end else begin
      read_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          mdc     <= 1'b0;
          mdio_oe <= 1'b0;
          mdio_o  <= 1'b1;
          if (cmd_valid) begin
            state     <= SHIFT;
            cmd_ready <= 1'b0;
            is_read   <= read_write;
            mdio_o    <= frame_full[63];
            mdio_oe   <= 1'b1;
            frame_sr  <= {frame_full[62:0], 1'b1};
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_cnt   <= 6'd0;
          end
        end

        SHIFT: begin
          if (sample) begin
            if (bit_cnt == 6'd47) ta_bit <= mdio_i;
            if (bit_cnt >= 6'd48) rd_stage <= rd_next;
          end

          if (!div_last) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (!phase) begin
              mdc <= 1'b1;
            end else if (bit_cnt == 6'd63) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              mdc       <= 1'b0;
              mdio_oe   <= 1'b0;
              mdio_o    <= 1'b1;
              if (is_read) begin
                read_data_valid <= 1'b1;
                read_data       <= rd_final;
                read_err        <= ta_bit;
              end
            end else begin
              bit_cnt  <= bit_cnt + 6'd1;
              mdc      <= 1'b0;
              mdio_o   <= frame_sr[63];
              frame_sr <= {frame_sr[62:0], 1'b1};
              // Reads release the line from bit 46 (TA) onwards.
              mdio_oe  <= !is_read || (bit_cnt < 6'd45);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - self-checking bench for mdio_master at CLK_DIV=2 and CLK_DIV=1
module tb_mdio_master;

  localparam logic [4:0] PHY = 5'h01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, cmd_valid, read_write, mdio_i, sel;
  logic [4:0]  reg_adr;
  logic [15:0] write_data;

  logic        cv0, rdy0, rdv0, err0, mdc0, o0, oe0;
  logic        cv1, rdy1, rdv1, err1, mdc1, o1, oe1;
  logic [15:0] rd0, rd1;

  logic        cmd_ready, read_data_valid, read_err, mdc, mdio_o, mdio_oe;
  logic [15:0] read_data;

  assign cv0 = cmd_valid & ~sel;
  assign cv1 = cmd_valid & sel;
  assign cmd_ready       = sel ? rdy1 : rdy0;
  assign read_data_valid = sel ? rdv1 : rdv0;
  assign read_data       = sel ? rd1  : rd0;
  assign read_err        = sel ? err1 : err0;
  assign mdc             = sel ? mdc1 : mdc0;
  assign mdio_o          = sel ? o1   : o0;
  assign mdio_oe         = sel ? oe1  : oe0;

  mdio_master #(.CLK_DIV(2), .PHY_ADDR(PHY)) u_div2 (
    .clk(clk), .resetn(resetn), .cmd_valid(cv0), .cmd_ready(rdy0),
    .read_write(read_write), .reg_adr(reg_adr), .write_data(write_data),
    .read_data_valid(rdv0), .read_data(rd0), .read_err(err0),
    .mdc(mdc0), .mdio_o(o0), .mdio_oe(oe0), .mdio_i(mdio_i));

  mdio_master #(.CLK_DIV(1), .PHY_ADDR(PHY)) u_div1 (
    .clk(clk), .resetn(resetn), .cmd_valid(cv1), .cmd_ready(rdy1),
    .read_write(read_write), .reg_adr(reg_adr), .write_data(write_data),
    .read_data_valid(rdv1), .read_data(rd1), .read_err(err1),
    .mdc(mdc1), .mdio_o(o1), .mdio_oe(oe1), .mdio_i(mdio_i));

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] last_rd [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rdv"}, read_data_valid, 0);
    check({tag, "_read_data"}, read_data, 0);
    check({tag, "_read_err"}, read_err, 0);
    check({tag, "_mdc"}, mdc, 0);
    check({tag, "_mdio_o"}, mdio_o, 1);
    check({tag, "_mdio_oe"}, mdio_oe, 0);
  endtask

  // Issues one command (called at a negedge) and follows the whole frame cycle by
  // cycle against the frame timing and contents derived from the command fields.
  task automatic run_frame(input string tag, input int dv, input bit rw,
                           input logic [4:0] ra, input logic [15:0] wd,
                           input bit present, input logic [15:0] resp, input bit ta,
                           input bit hold, input int abort_bit,
                           input bit chain, input bit c_rw, input logic [4:0] c_ra,
                           input logic [15:0] c_wd);
    logic [63:0] exp_frame, exp_oe, cap_o, cap_oe;
    logic [15:0] exp_rd;
    logic        exp_err;
    int e, k, bad_mdc, bad_ready, bad_oe, bad_rdv, bad_rd;
    e = 128 * dv + 1;
    bad_mdc = 0; bad_ready = 0; bad_oe = 0; bad_rdv = 0; bad_rd = 0;
    cap_o = '0; cap_oe = '0;
    exp_frame = {32'hFFFF_FFFF, 2'b01, rw ? 2'b10 : 2'b01, PHY, ra, 2'b10, wd};
    exp_oe    = rw ? ~64'h3FFFF : '1;
    exp_rd    = present ? resp : 16'hFFFF;
    exp_err   = present ? ta : 1'b1;

    read_write = rw; reg_adr = ra; write_data = wd; cmd_valid = 1'b1; mdio_i = 1'b1;
    check({tag, "_ready_at_issue"}, cmd_ready, 1);
    @(posedge clk);
    for (int n = 1; n < e; n++) begin
      @(negedge clk);
      k = (n - 1) / (2 * dv);
      if ((n - 1) % (2 * dv) == 0) begin
        cap_o[63-k]  = mdio_o;
        cap_oe[63-k] = mdio_oe;
        if (k == abort_bit) begin
          resetn = 1'b0; cmd_valid = 1'b0; mdio_i = 1'b1;
          @(negedge clk);
          check({tag, "_abort_mdc"}, mdc, 0);
          check({tag, "_abort_oe"}, mdio_oe, 0);
          check({tag, "_abort_ready"}, cmd_ready, 1);
          check({tag, "_abort_rdv"}, read_data_valid, 0);
          check({tag, "_abort_rd"}, read_data, 0);
          last_rd[sel] = 16'h0000;
          resetn = 1'b1;
          @(negedge clk);
          check({tag, "_abort_no_strobe"}, read_data_valid, 0);
          return;
        end
        mdio_i = (rw && present) ? ((k == 47) ? ta : ((k >= 48) ? resp[63-k] : 1'b1)) : 1'b1;
      end
      if (mdc !== ((((n - 1) / dv) % 2) == 1)) bad_mdc++;
      if (cmd_ready !== 1'b0) bad_ready++;
      if (mdio_oe !== exp_oe[63-k]) bad_oe++;
      if (read_data_valid !== 1'b0) bad_rdv++;
      if (read_data !== last_rd[sel]) bad_rd++;
      // Commands offered while busy (with scrambled fields) must be ignored.
      cmd_valid = hold ? 1'b1 : ((n < e - 3) && ($urandom_range(7) == 0));
      if (cmd_valid) begin
        reg_adr = 5'($urandom); write_data = 16'($urandom); read_write = 1'($urandom);
      end
    end
    @(negedge clk);
    check({tag, "_E_ready"}, cmd_ready, 1);
    check({tag, "_E_mdc"}, mdc, 0);
    check({tag, "_E_oe"}, mdio_oe, 0);
    check({tag, "_E_mdio_o"}, mdio_o, 1);
    check({tag, "_E_rdv"}, read_data_valid, rw);
    if (rw) begin
      check({tag, "_read_data"}, read_data, exp_rd);
      check({tag, "_read_err"}, read_err, exp_err);
      last_rd[sel] = exp_rd;
    end else begin
      check({tag, "_read_data_held"}, read_data, last_rd[sel]);
    end
    check({tag, "_frame"}, cap_o & exp_oe, exp_frame & exp_oe);
    check({tag, "_oe_pattern"}, cap_oe, exp_oe);
    check({tag, "_mdc_bad_cycles"}, bad_mdc, 0);
    check({tag, "_busy_bad_cycles"}, bad_ready, 0);
    check({tag, "_oe_bad_cycles"}, bad_oe, 0);
    check({tag, "_rdv_bad_cycles"}, bad_rdv, 0);
    check({tag, "_rd_bad_cycles"}, bad_rd, 0);
    mdio_i = 1'b1;
    if (chain) begin
      read_write = c_rw; reg_adr = c_ra; write_data = c_wd; cmd_valid = 1'b1;
    end else begin
      cmd_valid = 1'b0;
      @(negedge clk);
      check({tag, "_strobe_one_cycle"}, read_data_valid, 0);
      check({tag, "_idle_ready"}, cmd_ready, 1);
    end
  endtask

  task automatic random_frames(input string tag, input int dv, input int count);
    bit rw, present, ta;
    logic [4:0]  ra;
    logic [15:0] wd, resp;
    for (int i = 0; i < count; i++) begin
      rw = 1'($urandom); ra = 5'($urandom); wd = 16'($urandom); resp = 16'($urandom);
      present = ($urandom_range(3) != 0);
      ta = ($urandom_range(3) == 0);
      run_frame(tag, dv, rw, ra, wd, present, resp, ta, 0, -1, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int bad_idle;
    sel = 1'b0; resetn = 1'b0; cmd_valid = 1'b0; read_write = 1'b0;
    reg_adr = 5'h00; write_data = 16'h0000; mdio_i = 1'b1;
    last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_state("reset_div2");
    sel = 1'b1;
    check_reset_state("reset_div1");
    sel = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    run_frame("t1_write", 2, 0, 5'h00, 16'h8000, 1, 16'h0000, 0, 0, -1, 0, 0, 0, 0);
    run_frame("t2_read", 2, 1, 5'h01, 16'h0000, 1, 16'h796D, 0, 0, -1, 0, 0, 0, 0);
    run_frame("t3_absent", 2, 1, 5'h02, 16'h0000, 0, 16'h0000, 0, 0, -1, 0, 0, 0, 0);
    run_frame("t4_b2b_rd", 2, 1, 5'h1F, 16'h0000, 1, 16'h1234, 0, 1, -1, 1, 0, 5'h0A, 16'hBEEF);
    run_frame("t4_b2b_wr", 2, 0, 5'h0A, 16'hBEEF, 1, 16'h0000, 0, 0, -1, 0, 0, 0, 0);
    bad_idle = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b1 || mdc !== 1'b0 || mdio_oe !== 1'b0) bad_idle++;
    end
    check("t4_no_extra_frame", bad_idle, 0);

    run_frame("t5_abort", 2, 1, 5'h03, 16'h0000, 1, 16'hC3C3, 0, 0, 40, 0, 0, 0, 0);
    run_frame("t5_after", 2, 0, 5'h11, 16'h5A5A, 1, 16'h0000, 0, 0, -1, 0, 0, 0, 0);
    random_frames("rand_div2", 2, 4);

    sel = 1'b1;
    @(negedge clk);
    run_frame("t6_div1", 1, 1, 5'h04, 16'h0000, 1, 16'hA5A5, 0, 0, -1, 0, 0, 0, 0);
    random_frames("rand_div1", 1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
